// File: rtl/d2_pkg.sv
// Shared definitions for the decode-two micro-op sequencer: state encoding,
// default sizing constants and the micro-op count clamp.
`default_nettype none

package d2_pkg;

   typedef enum logic [0:0] {
      D2_IDLE  = 1'b0,
      D2_ISSUE = 1'b1
   } d2_state_e;

   localparam int unsigned D2_DEF_UOP_W    = 3;
   localparam int unsigned D2_DEF_MAX_UOPS = 4;

   // A zero request still issues one micro-op; oversize requests saturate.
   function automatic int unsigned d2_clamp_cnt(input int unsigned cnt,
                                                input int unsigned max_uops);
      if (cnt == 0)
         return 1;
      else if (cnt > max_uops)
         return max_uops;
      else
         return cnt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/d2_uop_sequencer_if.sv
// Decode-one / AG handshake bundle seen by the decode-two sequencer.
`default_nettype none

interface d2_uop_sequencer_if #(
   parameter int IR_W  = 128,
   parameter int UOP_W = 3
);
   logic             FLUSH;
   logic             D1_V;
   logic             D1_READY;
   logic [IR_W-1:0]  D1_IR;
   logic [31:0]      D1_EIP;
   logic [3:0]       D1_LEN;
   logic [15:0]      D1_CS;
   logic [UOP_W-1:0] D1_UOP_CNT;
   logic             AG_STALL;
   logic             D2_V;
   logic [IR_W-1:0]  D2_IR;
   logic [31:0]      D2_EIP;
   logic [31:0]      D2_NEXT_EIP;
   logic [15:0]      D2_CS;
   logic [UOP_W-1:0] D2_UOP_IDX;
   logic             D2_UOP_LAST;

   modport master (
      output FLUSH, D1_V, D1_IR, D1_EIP, D1_LEN, D1_CS, D1_UOP_CNT, AG_STALL,
      input  D1_READY, D2_V, D2_IR, D2_EIP, D2_NEXT_EIP, D2_CS, D2_UOP_IDX,
             D2_UOP_LAST
   );

   modport slave (
      input  FLUSH, D1_V, D1_IR, D1_EIP, D1_LEN, D1_CS, D1_UOP_CNT, AG_STALL,
      output D1_READY, D2_V, D2_IR, D2_EIP, D2_NEXT_EIP, D2_CS, D2_UOP_IDX,
             D2_UOP_LAST
   );
endinterface

`default_nettype wire

// File: rtl/d2_hold_reg.sv
// Enable-loaded holding register with asynchronous active-low clear.
`default_nettype none

module d2_hold_reg #(
   parameter int W = 8
) (
   input  wire logic         i_clk,
   input  wire logic         i_rst_n,
   input  wire logic         i_en,
   input  wire logic [W-1:0] i_d,
   output logic      [W-1:0] o_q
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_q <= '0;
      else if (i_en)
         o_q <= i_d;
   end

endmodule

`default_nettype wire

// File: rtl/d2_uop_sequencer.sv
// Decode-two sequencer: latches one decoded instruction and issues it to AG
// as 1..MAX_UOPS indexed micro-ops under a valid/stall handshake with flush.
`default_nettype none

module d2_uop_sequencer
   import d2_pkg::*;
#(
   parameter int          IR_W     = 128,
   parameter int          UOP_W    = int'(D2_DEF_UOP_W),
   parameter int unsigned MAX_UOPS = D2_DEF_MAX_UOPS
) (
   input wire logic           CLK,
   input wire logic           RST,
   d2_uop_sequencer_if.slave  bus
);

   d2_state_e        r_state;
   d2_state_e        w_state_nxt;
   logic [UOP_W-1:0] r_idx;
   logic [UOP_W-1:0] w_idx_nxt;
   logic [UOP_W-1:0] w_cnt;
   logic [UOP_W-1:0] w_eff_cnt;
   logic [31:0]      w_next_eip;
   logic             w_issue;
   logic             w_last;
   logic             w_ready;
   logic             w_accept;
   logic             w_consume;

   assign w_eff_cnt  = UOP_W'(d2_clamp_cnt(32'(bus.D1_UOP_CNT), MAX_UOPS));
   assign w_next_eip = bus.D1_EIP + {28'b0, bus.D1_LEN};

   assign w_issue   = (r_state == D2_ISSUE);
   assign w_last    = w_issue && (r_idx == (w_cnt - UOP_W'(1)));
   // Ready looks straight through AG_STALL so the last micro-op and the next
   // bundle can hand over on the same edge without a bubble.
   assign w_ready   = RST && !bus.FLUSH && (!w_issue || (w_last && !bus.AG_STALL));
   assign w_accept  = bus.D1_V && w_ready;
   assign w_consume = w_issue && !bus.AG_STALL;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      if (bus.FLUSH) begin
         w_state_nxt = D2_IDLE;
         w_idx_nxt   = '0;
      end else if (w_accept) begin
         w_state_nxt = D2_ISSUE;
         w_idx_nxt   = '0;
      end else if (w_consume) begin
         if (w_last) begin
            w_state_nxt = D2_IDLE;
            w_idx_nxt   = '0;
         end else begin
            w_idx_nxt = r_idx + UOP_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= D2_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   d2_hold_reg #(.W(IR_W)) u_ir (
      .i_clk(CLK), .i_rst_n(RST), .i_en(w_accept), .i_d(bus.D1_IR), .o_q(bus.D2_IR)
   );

   d2_hold_reg #(.W(32)) u_eip (
      .i_clk(CLK), .i_rst_n(RST), .i_en(w_accept), .i_d(bus.D1_EIP), .o_q(bus.D2_EIP)
   );

   d2_hold_reg #(.W(32)) u_next_eip (
      .i_clk(CLK), .i_rst_n(RST), .i_en(w_accept), .i_d(w_next_eip), .o_q(bus.D2_NEXT_EIP)
   );

   d2_hold_reg #(.W(16)) u_cs (
      .i_clk(CLK), .i_rst_n(RST), .i_en(w_accept), .i_d(bus.D1_CS), .o_q(bus.D2_CS)
   );

   d2_hold_reg #(.W(UOP_W)) u_cnt (
      .i_clk(CLK), .i_rst_n(RST), .i_en(w_accept), .i_d(w_eff_cnt), .o_q(w_cnt)
   );

   assign bus.D1_READY    = w_ready;
   assign bus.D2_V        = w_issue;
   assign bus.D2_UOP_IDX  = r_idx;
   assign bus.D2_UOP_LAST = w_last;

endmodule

`default_nettype wire

// File: doc/d2_uop_sequencer.md
Name: d2_uop_sequencer

Overview:
Parametrised decode-two sequencer that sits between decode-one and address generation (AG). It latches one decoded instruction (IR, EIP, length, CS, micro-op count) and issues it to AG as 1..MAX_UOPS micro-ops, one per cycle. Each micro-op carries an index and a last flag. Issue follows a valid/stall handshake and supports flush; next-EIP arithmetic is included.

Parameters:
IR_W, 128, width of the instruction register bundle carried per micro-op
UOP_W, 3, width of micro-op count and index fields
MAX_UOPS, 4, maximum micro-ops per instruction; larger requested counts clamp to this (must be <= 2^UOP_W - 1)

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  asynchronous active-low reset
FLUSH  in  1  synchronous pipeline flush (branch/exception)
D1_V  in  1  decode-one bundle valid
D1_READY  out  1  sequencer accepts bundle this cycle
D1_IR  in  IR_W  instruction bytes
D1_EIP  in  32  instruction EIP
D1_LEN  in  4  instruction length in bytes
D1_CS  in  16  code segment
D1_UOP_CNT  in  UOP_W  requested micro-op count
AG_STALL  in  1  AG cannot take a micro-op this cycle
D2_V  out  1  micro-op valid to AG
D2_IR  out  IR_W  held IR
D2_EIP  out  32  held EIP
D2_NEXT_EIP  out  32  D2_EIP + D2 length, modulo 2^32
D2_CS  out  16  held CS
D2_UOP_IDX  out  UOP_W  current micro-op index, 0-based
D2_UOP_LAST  out  1  current micro-op is the final one

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; all outputs and held registers 0; D1_READY=0 while RST=0.
- States: IDLE (D2_V=0) and ISSUE (D2_V=1).
- Accept: fires when D1_V && D1_READY. The bundle is captured on that edge. Next cycle: ISSUE, D2_UOP_IDX=0. Latency is 1 cycle.
- Effective count: D1_UOP_CNT==0 is treated as 1; values >MAX_UOPS are treated as MAX_UOPS. The effective count is stored.
- D2_UOP_LAST = (D2_UOP_IDX == stored_count-1), valid only when D2_V=1; otherwise 0.
- Consume: fires when D2_V && !AG_STALL.
  - Not last: D2_UOP_IDX increments next edge.
  - Last: if an accept occurs in the same cycle, the new bundle loads and state stays ISSUE (back-to-back, no bubble); otherwise state goes to IDLE.
- Stall: while AG_STALL=1, all D2_* outputs hold stable.
- D1_READY = RST && !FLUSH && (state==IDLE || (D2_UOP_LAST && !AG_STALL)). It is combinational from AG_STALL and FLUSH.
- FLUSH has priority over accept and consume. Next edge: IDLE, D2_V=0, D2_UOP_IDX=0. Any bundle presented during the FLUSH cycle is not accepted. Held data may remain but is ignored.
- D2_NEXT_EIP is registered at accept as D1_EIP + {28'b0,D1_LEN}; carry out of bit 31 is discarded (wrap).
- Reset mid-sequence aborts immediately; no micro-op is reissued after reset release.
- D2_* data outputs are don't-care when D2_V=0 except D2_UOP_LAST, which must be 0.

Decomposition:
- Shared package d2_pkg: state encoding (D2_IDLE, D2_ISSUE), default UOP_W/MAX_UOPS constants, count-clamp function.
- Sub-module d2_hold_reg: parametrised-width enable register with async active-low clear. Instantiated for IR, EIP, NEXT_EIP, CS and count.
- Index counter and FSM live in the top module.

Test Plan:
- Single micro-op: D1_UOP_CNT=1, EIP=0x00001000, LEN=3, AG_STALL=0 -> next cycle D2_V=1, IDX=0, LAST=1, NEXT_EIP=0x00001003; following cycle D2_V=0.
- Multi-op with stall: CNT=3, AG_STALL=1 on the second issue cycle -> IDX sequence 0,1,1,2; LAST only on IDX=2; D1_READY=1 only in the final unstalled cycle.
- Back-to-back: A (CNT=2), then B (CNT=1) offered continuously -> D2_V stays high for 3 cycles, IDX 0,1,0, no bubble.
- Clamp and zero: CNT=7 with MAX_UOPS=4 -> exactly 4 micro-ops (IDX 0..3); CNT=0 -> exactly 1 micro-op.
- Flush mid-sequence: CNT=4, FLUSH at IDX=1 with D1_V=1 -> next cycle D2_V=0, bundle not accepted, D1_READY=0 during FLUSH cycle.
- Wrap and reset: EIP=0xFFFFFFFE, LEN=5 -> NEXT_EIP=0x00000003; RST low at IDX=1 of a CNT=3 sequence -> D2_V=0 immediately, IDLE after release.
